// File: rtl/haar_pass_scheduler.sv
// rtl/haar_pass_scheduler.sv - row/column pass sequencer feeding the Haar MAC; define HAAR_SINGLE_PASS_EN for a row-pass-only build
module haar_pass_scheduler #(
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256,
  localparam int AW = $clog2(WIDTH),
  localparam int MW = $clog2(HEIGHT * WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mem_rd,
  output logic [MW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic [15:0]   mac_pixel,
  output logic          mac_valid,
  output logic [AW-1:0] mac_row_column_pointer,
  output logic [AW-1:0] mac_pixel_pointer,
  input  logic          mac_o_valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [AW-1:0] ONE_AW = AW'(1);
  localparam logic [MW-1:0] ONE_MW = MW'(1);
  localparam logic [AW-1:0] P_LAST = AW'(WIDTH / 2 - 1);
  localparam logic [AW-1:0] L_LAST = AW'(HEIGHT - 1);

  state_t        state, state_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] line_q, line_d;
  logic [AW-1:0] p_q, p_d;
  logic [MW-1:0] outstanding, out_d;
  logic [7:0]    hi_q, lo_q;
  logic [AW-1:0] rc_q, pp_q;
  logic          issue;
  logic          dec;
  logic [MW-1:0] addr_a, addr_b;

  assign issue = (state == ISSUE);
  assign dec   = mac_o_valid && (outstanding != '0);
  assign pass  = pass_q;

  // Pair addresses are bit concatenations because the image is square and a power of two.
  assign addr_a = pass_q ? {p_q[AW-2:0], 1'b0, line_q} : {line_q, p_q[AW-2:0], 1'b0};
  assign addr_b = pass_q ? {p_q[AW-2:0], 1'b1, line_q} : {line_q, p_q[AW-2:0], 1'b1};

  // Operand and pointers show the live pair during ISSUE and hold the last issued pair otherwise.
  assign mac_pixel              = issue ? {hi_q, mem_data} : {hi_q, lo_q};
  assign mac_row_column_pointer = issue ? line_q : rc_q;
  assign mac_pixel_pointer      = issue ? p_q : pp_q;

  // Outstanding MAC results: issue adds, result retires, empty counter ignores stray results.
  always_comb begin
    out_d = outstanding;
    if (issue && !dec) begin
      out_d = outstanding + ONE_MW;
    end else if (!issue && dec) begin
      out_d = outstanding - ONE_MW;
    end
  end

  // Next-state and strobe decode; drain exits on the cycle the last result retires.
  always_comb begin
    state_d   = state;
    pass_d    = pass_q;
    line_d    = line_q;
    p_d       = p_q;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mac_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          pass_d  = 1'b0;
          line_d  = '0;
          p_d     = '0;
        end
      end
      RD_A: begin
        busy = 1'b1;
        if (!hold) begin
          mem_rd   = 1'b1;
          mem_addr = addr_a;
          state_d  = RD_B;
        end
      end
      RD_B: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = addr_b;
        state_d  = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        mac_valid = 1'b1;
        state_d   = RD_A;
        if (p_q == P_LAST) begin
          p_d    = '0;
          line_d = line_q + ONE_AW;
          if (line_q == L_LAST) begin
            state_d = DRAIN;
          end
        end else begin
          p_d = p_q + ONE_AW;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_d == '0) begin
`ifdef HAAR_SINGLE_PASS_EN
          state_d = FIN;
`else
          if (!pass_q) begin
            pass_d  = 1'b1;
            line_d  = '0;
            p_d     = '0;
            state_d = RD_A;
          end else begin
            state_d = FIN;
          end
`endif
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pass_q      <= 1'b0;
      line_q      <= '0;
      p_q         <= '0;
      outstanding <= '0;
    end else begin
      state       <= state_d;
      pass_q      <= pass_d;
      line_q      <= line_d;
      p_q         <= p_d;
      outstanding <= out_d;
    end
  end

  // Operand capture: first pixel lands in RD_B, second pixel and pointers are held after ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      rc_q <= '0;
      pp_q <= '0;
    end else begin
      if (state == RD_B) begin
        hi_q <= mem_data;
      end
      if (issue) begin
        lo_q <= mem_data;
        rc_q <= line_q;
        pp_q <= p_q;
      end
    end
  end

endmodule

// File: tb/tb_haar_pass_scheduler.sv
// tb/tb_haar_pass_scheduler.sv - directed table-driven bench for haar_pass_scheduler on a 4x4 ramp image
module tb_haar_pass_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy, done, pass, mem_rd, mac_valid, mac_o_valid;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data = 8'd0;
  logic [15:0] mac_pixel;
  logic [1:0]  mac_row_column_pointer, mac_pixel_pointer;

  haar_pass_scheduler #(.HEIGHT(4), .WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hold(hold),
    .busy(busy),
    .done(done),
    .pass(pass),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mac_pixel(mac_pixel),
    .mac_valid(mac_valid),
    .mac_row_column_pointer(mac_row_column_pointer),
    .mac_pixel_pointer(mac_pixel_pointer),
    .mac_o_valid(mac_o_valid)
  );

  always #5 clk = ~clk;

  // Ramp frame buffer: pixel value equals its address, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= {4'd0, mem_addr};
  end

  // MAC model with programmable latency.
  int         lat = 1;
  logic [7:0] vpipe = 8'd0;
  always @(posedge clk or posedge rst) begin
    if (rst) vpipe <= 8'd0;
    else     vpipe <= {vpipe[6:0], mac_valid};
  end
  assign mac_o_valid = vpipe[lat[2:0] - 3'd1];

  typedef struct {
    int          cyc;
    logic [15:0] pix;
    logic [1:0]  rc;
    logic [1:0]  pp;
    logic        ps;
  } rec_t;

`ifdef HAAR_SINGLE_PASS_EN
  localparam int NISS = 8;
`else
  localparam int NISS = 16;
`endif

  rec_t tbl [16];
  rec_t got [$];

  int cnt = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  int done_cyc, busy_gap, stab_bad, hold_viol, hold_low;

  always @(posedge clk) cnt <= cnt + 1;

  // Observation at the falling edge: issue log, done time, busy gaps, operand stability, hold behaviour.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mac_valid) begin
        got.push_back('{cnt - t0, mac_pixel, mac_row_column_pointer, mac_pixel_pointer, pass});
      end else if (got.size() > 0) begin
        if ({mac_pixel, mac_row_column_pointer, mac_pixel_pointer} !== {got[$].pix, got[$].rc, got[$].pp})
          stab_bad++;
      end
      if (done && done_cyc < 0) done_cyc = cnt - t0;
      if (!busy && !done && done_cyc < 0 && cnt != t0) busy_gap++;
      if (hold && (mem_rd || mac_valid)) hold_viol++;
      if (hold && !mem_rd) hold_low++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int lat_i, input int hs, input int hl, input int sp, input int rst_at);
    lat = lat_i;
    got.delete();
    done_cyc = -1; busy_gap = 0; stab_bad = 0; hold_viol = 0; hold_low = 0;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cnt;
    mon_en = 1'b1;
    for (int i = 1; i < 400; i++) begin
      @(posedge clk); #1;
      start = (i == sp);
      hold  = (i >= hs && i < hs + hl);
      if (i == rst_at) begin
        rst = 1'b1;
        break;
      end
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    hold = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic verify(input int lat_i, input int hl);
    int exp_cyc;
    int exp_done;
    chk("issue_count", got.size(), NISS);
    for (int k = 0; k < NISS; k++) begin
      if (k < got.size()) begin
        exp_cyc = tbl[k].cyc + ((k >= 1) ? hl : 0) + (tbl[k].ps ? lat_i - 1 : 0);
        chk($sformatf("issue%0d_cycle", k), got[k].cyc, exp_cyc);
        chk($sformatf("issue%0d_pixel", k), {16'd0, got[k].pix}, {16'd0, tbl[k].pix});
        chk($sformatf("issue%0d_ptrs", k), {27'd0, got[k].rc, got[k].pp, got[k].ps},
            {27'd0, tbl[k].rc, tbl[k].pp, tbl[k].ps});
      end
    end
`ifdef HAAR_SINGLE_PASS_EN
    exp_done = 24 + hl + lat_i + 1;
`else
    exp_done = 49 + hl + (lat_i - 1) + lat_i + 1;
`endif
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_gap", busy_gap, 0);
    chk("operand_stable", stab_bad, 0);
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3,  16'h0001, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{6,  16'h0203, 2'd0, 2'd1, 1'b0};
    tbl[2]  = '{9,  16'h0405, 2'd1, 2'd0, 1'b0};
    tbl[3]  = '{12, 16'h0607, 2'd1, 2'd1, 1'b0};
    tbl[4]  = '{15, 16'h0809, 2'd2, 2'd0, 1'b0};
    tbl[5]  = '{18, 16'h0a0b, 2'd2, 2'd1, 1'b0};
    tbl[6]  = '{21, 16'h0c0d, 2'd3, 2'd0, 1'b0};
    tbl[7]  = '{24, 16'h0e0f, 2'd3, 2'd1, 1'b0};
    tbl[8]  = '{28, 16'h0004, 2'd0, 2'd0, 1'b1};
    tbl[9]  = '{31, 16'h080c, 2'd0, 2'd1, 1'b1};
    tbl[10] = '{34, 16'h0105, 2'd1, 2'd0, 1'b1};
    tbl[11] = '{37, 16'h090d, 2'd1, 2'd1, 1'b1};
    tbl[12] = '{40, 16'h0206, 2'd2, 2'd0, 1'b1};
    tbl[13] = '{43, 16'h0a0e, 2'd2, 2'd1, 1'b1};
    tbl[14] = '{46, 16'h0307, 2'd3, 2'd0, 1'b1};
    tbl[15] = '{49, 16'h0b0f, 2'd3, 2'd1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, pass, mem_rd, mem_addr, mac_pixel, mac_valid,
                          mac_row_column_pointer, mac_pixel_pointer}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Abort in the middle of pair 5 of the row pass.
    run(1, -1, 0, -1, 14);
    chk("pairs_before_abort", got.size(), 4);
    @(negedge clk);
    chk("abort_outputs", {busy, done, pass, mem_rd, mem_addr, mac_pixel, mac_valid,
                          mac_row_column_pointer, mac_pixel_pointer}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full transform, latency-1 MAC, no backpressure; also proves restart from address 0.
    run(1, -1, 0, -1, -1);
    verify(1, 0);

    // Five cycles of hold while waiting in RD_A of pair 2.
    run(1, 4, 5, -1, -1);
    chk("hold_rd_low_cycles", hold_low, 5);
    chk("hold_no_activity", hold_viol, 0);
    verify(1, 5);

    // Latency-4 MAC stretches the drain; a start pulse while busy must be ignored.
    run(4, -1, 0, 10, -1);
    verify(4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
